// File: rtl/dep_tracker_id_pkg.sv
// Shared types and constants for the decode-stage dependency tracker.
// Holds the per-slot metadata record, the stage indices used to address the
// EX/MEM/WB shadow slots, and the helper that decides whether a slot writes.
package dep_tracker_id_pkg;

   localparam int REG_SIZE   = 5;
   localparam int DEP_STAGES = 3;
   localparam int PERF_W     = 32;

   typedef enum logic [1:0] {
      DEP_EX  = 2'd0,
      DEP_MEM = 2'd1,
      DEP_WB  = 2'd2
   } dep_stage_e;

   typedef struct packed {
      logic                valid;
      logic                wr;
      logic                load;
      logic [REG_SIZE-1:0] rd;
   } dep_slot_t;

   // A slot only counts as a producer when it really writes a non-x0 register
   function automatic logic slot_writing(dep_slot_t slot);
      return slot.valid & slot.wr & (slot.rd != '0);
   endfunction

endpackage

// File: rtl/dep_tracker_id_if.sv
// Bundle of decode-side inputs and dependency outputs exchanged between the
// decoder/bypass logic (master) and the dependency tracker (slave).
interface dep_tracker_id_if;
   import dep_tracker_id_pkg::*;

   logic                id_valid_i;
   logic [REG_SIZE-1:0] id_rd_i;
   logic                id_wr_i;
   logic                id_load_i;
   logic [REG_SIZE-1:0] src_a_identifier_id_i;
   logic [REG_SIZE-1:0] src_b_identifier_id_i;
   logic                rd_src_a_id_i;
   logic                rd_src_b_id_i;
   logic                mem_busy_i;
   logic                flush_i;

   logic                valid_ex_o;
   logic                valid_mem_o;
   logic                valid_wb_o;
   logic                data_produced_ex_o;
   logic                data_produced_mem_o;
   logic                data_produced_wb_o;
   logic [REG_SIZE-1:0] dst_reg_identifier_ex_o;
   logic [REG_SIZE-1:0] dst_reg_identifier_mem_o;
   logic [REG_SIZE-1:0] dst_reg_identifier_wb_o;
   logic                depEX_src_a_o;
   logic                depEX_src_b_o;
   logic                depMEM_src_a_o;
   logic                depMEM_src_b_o;
   logic                depWB_src_a_o;
   logic                depWB_src_b_o;
   logic                stall_id_o;

   modport slave (
      input  id_valid_i, id_rd_i, id_wr_i, id_load_i,
      input  src_a_identifier_id_i, src_b_identifier_id_i,
      input  rd_src_a_id_i, rd_src_b_id_i, mem_busy_i, flush_i,
      output valid_ex_o, valid_mem_o, valid_wb_o,
      output data_produced_ex_o, data_produced_mem_o, data_produced_wb_o,
      output dst_reg_identifier_ex_o, dst_reg_identifier_mem_o, dst_reg_identifier_wb_o,
      output depEX_src_a_o, depEX_src_b_o, depMEM_src_a_o, depMEM_src_b_o,
      output depWB_src_a_o, depWB_src_b_o, stall_id_o
   );

   modport master (
      output id_valid_i, id_rd_i, id_wr_i, id_load_i,
      output src_a_identifier_id_i, src_b_identifier_id_i,
      output rd_src_a_id_i, rd_src_b_id_i, mem_busy_i, flush_i,
      input  valid_ex_o, valid_mem_o, valid_wb_o,
      input  data_produced_ex_o, data_produced_mem_o, data_produced_wb_o,
      input  dst_reg_identifier_ex_o, dst_reg_identifier_mem_o, dst_reg_identifier_wb_o,
      input  depEX_src_a_o, depEX_src_b_o, depMEM_src_a_o, depMEM_src_b_o,
      input  depWB_src_a_o, depWB_src_b_o, stall_id_o
   );

endinterface

// File: rtl/dep_tracker_id_match.sv
// dep_match: compares one decode source register against one in-flight slot.
// The source must actually be read and must not be x0 for a match to count.
module dep_match
   import dep_tracker_id_pkg::*;
(
   input  dep_slot_t           slot_i,
   input  logic [REG_SIZE-1:0] src_i,
   input  logic                rd_src_i,
   output logic                match_o
);

   assign match_o = slot_writing(slot_i) & rd_src_i & (src_i == slot_i.rd) & (src_i != '0);

endmodule

// File: rtl/dep_tracker_id.sv
// dep_tracker_id: decode-stage dependency tracker shadowing the EX, MEM and WB
// slots with destination metadata. Produces raw per-stage match flags, slot
// validity / data-produced flags and a load-use stall for the bypass control.
// Optional feature macro: DEP_TRACKER_PERF_CNT_EN adds stall_cnt_o, a wrapping
// count of load-use stall cycles that actually advanced the pipeline.
module dep_tracker_id
   import dep_tracker_id_pkg::*;
(
   input  logic              clk_i,
   input  logic              rsn_i,
   dep_tracker_id_if.slave   bus
`ifdef DEP_TRACKER_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] stall_cnt_o
`endif
);

   dep_slot_t              slot_q [DEP_STAGES];
   dep_slot_t              exSlot_d;
   logic [DEP_STAGES-1:0]  writing;
   logic [DEP_STAGES-1:0]  depA;
   logic [DEP_STAGES-1:0]  depB;
   logic                   stall;
   logic                   advance;

   // One comparator pair per shadow slot, one for each decode source
   for (genvar s = 0; s < DEP_STAGES; s++) begin : g_match
      assign writing[s] = slot_writing(slot_q[s]);

      dep_match u_match_a (
         .slot_i   (slot_q[s]),
         .src_i    (bus.src_a_identifier_id_i),
         .rd_src_i (bus.rd_src_a_id_i),
         .match_o  (depA[s])
      );

      dep_match u_match_b (
         .slot_i   (slot_q[s]),
         .src_i    (bus.src_b_identifier_id_i),
         .rd_src_i (bus.rd_src_b_id_i),
         .match_o  (depB[s])
      );
   end

   assign advance = ~bus.mem_busy_i;

   // A load sitting in EX cannot forward yet, so a reader in ID must wait one cycle
   assign stall = bus.id_valid_i & (depA[DEP_EX] | depB[DEP_EX]) & slot_q[DEP_EX].load;

   // Build the next EX slot: the ID instruction, or an all-zero bubble when squashed or stalled
   always_comb begin
      exSlot_d = '0;
      if (bus.id_valid_i & ~stall & ~bus.flush_i) begin
         exSlot_d.valid = 1'b1;
         exSlot_d.wr    = bus.id_wr_i;
         exSlot_d.load  = bus.id_load_i;
         exSlot_d.rd    = bus.id_rd_i;
      end
   end

   // Shift the shadow slots in lockstep with the pipeline; a memory stall freezes everything
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         for (int i = 0; i < DEP_STAGES; i++) begin
            slot_q[i] <= '0;
         end
      end else if (advance) begin
         slot_q[DEP_WB]  <= slot_q[DEP_MEM];
         slot_q[DEP_MEM] <= slot_q[DEP_EX];
         slot_q[DEP_EX]  <= exSlot_d;
      end
   end

   assign bus.valid_ex_o               = writing[DEP_EX];
   assign bus.valid_mem_o              = writing[DEP_MEM];
   assign bus.valid_wb_o               = writing[DEP_WB];
   assign bus.data_produced_ex_o       = writing[DEP_EX] & ~slot_q[DEP_EX].load;
   assign bus.data_produced_mem_o      = writing[DEP_MEM];
   assign bus.data_produced_wb_o       = writing[DEP_WB];
   assign bus.dst_reg_identifier_ex_o  = slot_q[DEP_EX].rd;
   assign bus.dst_reg_identifier_mem_o = slot_q[DEP_MEM].rd;
   assign bus.dst_reg_identifier_wb_o  = slot_q[DEP_WB].rd;
   assign bus.depEX_src_a_o            = depA[DEP_EX];
   assign bus.depEX_src_b_o            = depB[DEP_EX];
   assign bus.depMEM_src_a_o           = depA[DEP_MEM];
   assign bus.depMEM_src_b_o           = depB[DEP_MEM];
   assign bus.depWB_src_a_o            = depA[DEP_WB];
   assign bus.depWB_src_b_o            = depB[DEP_WB];
   assign bus.stall_id_o               = stall;

`ifdef DEP_TRACKER_PERF_CNT_EN
   logic [PERF_W-1:0] stallCnt_q;

   // Count only stall cycles that really inserted a bubble (memory not busy)
   always_ff @(posedge clk_i or posedge rsn_i) begin
      if (rsn_i) begin
         stallCnt_q <= '0;
      end else if (stall & advance) begin
         stallCnt_q <= stallCnt_q + 1'b1;
      end
   end

   assign stall_cnt_o = stallCnt_q;
`endif

endmodule

// File: tb/tb_dep_tracker_id.sv
// Testbench for dep_tracker_id. A bench-side pipeline model predicts the full
// output vector; each drive pushes the prediction onto a scoreboard queue which
// the scenario tasks pop and compare once outputs have settled. Scenario tasks
// also check the specific flags each scenario is about against fixed values.
module tb_dep_tracker_id;
   import dep_tracker_id_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dep_tracker_id_if dif();

`ifdef DEP_TRACKER_PERF_CNT_EN
   logic [PERF_W-1:0] stallCnt;
`endif

   dep_tracker_id dut (
      .clk_i       (clk),
      .rsn_i       (rst),
      .bus         (dif)
`ifdef DEP_TRACKER_PERF_CNT_EN
      ,
      .stall_cnt_o (stallCnt)
`endif
   );

   typedef struct packed {
      logic       v;
      logic       wr;
      logic       ld;
      logic [4:0] rd;
   } mslot_t;

   mslot_t      mEx, mMem, mWb;
   int unsigned perfCnt;
   logic [27:0] sbq [$];
   logic [27:0] obs, exp;
   int          checks = 0;
   int          errors = 0;

   // Model: does a slot write a real register
   function automatic logic mWrites(mslot_t s);
      return s.v && s.wr && (s.rd != 5'd0);
   endfunction

   // Model: does a read source depend on a slot
   function automatic logic mDep(mslot_t s, logic [4:0] src, logic rdSrc);
      return mWrites(s) && rdSrc && (src == s.rd) && (src != 5'd0);
   endfunction

   function automatic logic modelStall();
      return dif.id_valid_i && mEx.ld &&
             (mDep(mEx, dif.src_a_identifier_id_i, dif.rd_src_a_id_i) ||
              mDep(mEx, dif.src_b_identifier_id_i, dif.rd_src_b_id_i));
   endfunction

   function automatic logic [27:0] modelVec();
      logic wE, wM, wW;
      wE = mWrites(mEx);
      wM = mWrites(mMem);
      wW = mWrites(mWb);
      return {wE, wM, wW, wE && !mEx.ld, wM, wW, mEx.rd, mMem.rd, mWb.rd,
              mDep(mEx,  dif.src_a_identifier_id_i, dif.rd_src_a_id_i),
              mDep(mEx,  dif.src_b_identifier_id_i, dif.rd_src_b_id_i),
              mDep(mMem, dif.src_a_identifier_id_i, dif.rd_src_a_id_i),
              mDep(mMem, dif.src_b_identifier_id_i, dif.rd_src_b_id_i),
              mDep(mWb,  dif.src_a_identifier_id_i, dif.rd_src_a_id_i),
              mDep(mWb,  dif.src_b_identifier_id_i, dif.rd_src_b_id_i),
              modelStall()};
   endfunction

   function automatic logic [27:0] dutVec();
      return {dif.valid_ex_o, dif.valid_mem_o, dif.valid_wb_o,
              dif.data_produced_ex_o, dif.data_produced_mem_o, dif.data_produced_wb_o,
              dif.dst_reg_identifier_ex_o, dif.dst_reg_identifier_mem_o, dif.dst_reg_identifier_wb_o,
              dif.depEX_src_a_o, dif.depEX_src_b_o, dif.depMEM_src_a_o, dif.depMEM_src_b_o,
              dif.depWB_src_a_o, dif.depWB_src_b_o, dif.stall_id_o};
   endfunction

   // Drive all ID-side inputs, record the prediction, then let outputs settle
   task automatic driveId(input logic v, input logic wr, input logic ld, input logic [4:0] rd,
                          input logic [4:0] sa, input logic ra, input logic [4:0] sb, input logic rb,
                          input logic busy, input logic fl);
      dif.id_valid_i            = v;
      dif.id_wr_i               = wr;
      dif.id_load_i             = ld;
      dif.id_rd_i               = rd;
      dif.src_a_identifier_id_i = sa;
      dif.rd_src_a_id_i         = ra;
      dif.src_b_identifier_id_i = sb;
      dif.rd_src_b_id_i         = rb;
      dif.mem_busy_i            = busy;
      dif.flush_i               = fl;
      sbq.push_back(modelVec());
      #1;
   endtask

   // Advance the model with the current inputs and move to just after the next rising edge
   task automatic tick();
      mslot_t nEx;
      logic   st;
      st = modelStall();
      if (rst) begin
         mEx = '0; mMem = '0; mWb = '0; perfCnt = 0;
      end else if (!dif.mem_busy_i) begin
         if (st) perfCnt++;
         nEx = '0;
         if (dif.id_valid_i && !st && !dif.flush_i) begin
            nEx.v  = 1'b1;
            nEx.wr = dif.id_wr_i;
            nEx.ld = dif.id_load_i;
            nEx.rd = dif.id_rd_i;
         end
         mWb  = mMem;
         mMem = mEx;
         mEx  = nEx;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) begin
         driveId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         exp = sbq.pop_front(); obs = dutVec(); checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL drain_vec got %h want %h", obs, exp); end
         tick();
      end
   endtask

   task automatic test_reset();
      driveId(1, 1, 0, 5, 5, 1, 5, 1, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL reset_vec got %h want %h", obs, exp); end
      checks++;
      if (obs !== 28'd0) begin errors++; $display("[TB] FAIL reset_zero got %h want 0", obs); end
      tick();
      driveId(1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL reset_held_vec got %h want %h", obs, exp); end
      rst = 1'b0;
      tick();
      driveId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL first_load_vec got %h want %h", obs, exp); end
      checks++;
      if ({dif.valid_ex_o, dif.dst_reg_identifier_ex_o} !== {1'b1, 5'd5}) begin
         errors++; $display("[TB] FAIL first_load got %b want 1_00101", {dif.valid_ex_o, dif.dst_reg_identifier_ex_o});
      end
      tick();
   endtask

   task automatic test_back_to_back();
      drain();
      driveId(1, 1, 0, 5, 0, 0, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL b2b_add_vec got %h want %h", obs, exp); end
      tick();
      driveId(1, 1, 0, 6, 5, 1, 1, 1, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL b2b_sub_vec got %h want %h", obs, exp); end
      checks++;
      if ({dif.depEX_src_a_o, dif.data_produced_ex_o, dif.stall_id_o} !== 3'b110) begin
         errors++; $display("[TB] FAIL b2b_ex got %b want 110", {dif.depEX_src_a_o, dif.data_produced_ex_o, dif.stall_id_o});
      end
      tick();
      driveId(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL b2b_mem_vec got %h want %h", obs, exp); end
      checks++;
      if ({dif.depEX_src_a_o, dif.depMEM_src_a_o, dif.depWB_src_a_o} !== 3'b010) begin
         errors++; $display("[TB] FAIL b2b_mem got %b want 010", {dif.depEX_src_a_o, dif.depMEM_src_a_o, dif.depWB_src_a_o});
      end
      tick();
      driveId(1, 0, 0, 0, 5, 1, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL b2b_wb_vec got %h want %h", obs, exp); end
      checks++;
      if ({dif.depEX_src_a_o, dif.depMEM_src_a_o, dif.depWB_src_a_o} !== 3'b001) begin
         errors++; $display("[TB] FAIL b2b_wb got %b want 001", {dif.depEX_src_a_o, dif.depMEM_src_a_o, dif.depWB_src_a_o});
      end
      tick();
   endtask

   task automatic test_load_use();
      drain();
      driveId(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL lu_lw_vec got %h want %h", obs, exp); end
      tick();
      driveId(1, 1, 0, 8, 1, 1, 7, 1, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL lu_stall_vec got %h want %h", obs, exp); end
      checks++;
      if ({dif.stall_id_o, dif.depEX_src_b_o, dif.data_produced_ex_o} !== 3'b110) begin
         errors++; $display("[TB] FAIL lu_stall got %b want 110", {dif.stall_id_o, dif.depEX_src_b_o, dif.data_produced_ex_o});
      end
      tick();
      driveId(1, 1, 0, 8, 1, 1, 7, 1, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL lu_bubble_vec got %h want %h", obs, exp); end
      checks++;
      if ({dif.stall_id_o, dif.depEX_src_b_o, dif.depMEM_src_b_o, dif.data_produced_mem_o, dif.valid_ex_o} !== 5'b00110) begin
         errors++; $display("[TB] FAIL lu_bubble got %b want 00110",
                            {dif.stall_id_o, dif.depEX_src_b_o, dif.depMEM_src_b_o, dif.data_produced_mem_o, dif.valid_ex_o});
      end
      tick();
      driveId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL lu_issue_vec got %h want %h", obs, exp); end
      checks++;
      if ({dif.valid_ex_o, dif.dst_reg_identifier_ex_o} !== {1'b1, 5'd8}) begin
         errors++; $display("[TB] FAIL lu_issue got %b want 1_01000", {dif.valid_ex_o, dif.dst_reg_identifier_ex_o});
      end
      tick();
   endtask

   task automatic test_x0();
      drain();
      driveId(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL x0_wr_vec got %h want %h", obs, exp); end
      tick();
      driveId(1, 1, 0, 4, 0, 1, 0, 1, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL x0_rd_vec got %h want %h", obs, exp); end
      checks++;
      if ({dif.valid_ex_o, dif.depEX_src_a_o, dif.depEX_src_b_o, dif.depMEM_src_a_o, dif.depMEM_src_b_o,
           dif.depWB_src_a_o, dif.depWB_src_b_o, dif.stall_id_o} !== 8'd0) begin
         errors++; $display("[TB] FAIL x0_flags got %b want 00000000",
                            {dif.valid_ex_o, dif.depEX_src_a_o, dif.depEX_src_b_o, dif.depMEM_src_a_o,
                             dif.depMEM_src_b_o, dif.depWB_src_a_o, dif.depWB_src_b_o, dif.stall_id_o});
      end
      tick();
   endtask

   task automatic test_mem_busy();
      drain();
      driveId(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL mb_lw_vec got %h want %h", obs, exp); end
      tick();
      driveId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL mb_nop_vec got %h want %h", obs, exp); end
      tick();
      for (int i = 0; i < 4; i++) begin
         driveId(1, 1, 0, 10, 3, 1, 0, 0, (i < 3), 0);
         exp = sbq.pop_front(); obs = dutVec(); checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL mb_hold_vec[%0d] got %h want %h", i, obs, exp); end
         checks++;
         if ({dif.depMEM_src_a_o, dif.dst_reg_identifier_mem_o, dif.stall_id_o} !== {1'b1, 5'd3, 1'b0}) begin
            errors++; $display("[TB] FAIL mb_hold[%0d] got %b want 1_00011_0", i,
                               {dif.depMEM_src_a_o, dif.dst_reg_identifier_mem_o, dif.stall_id_o});
         end
         tick();
      end
      driveId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL mb_resume_vec got %h want %h", obs, exp); end
      checks++;
      if ({dif.dst_reg_identifier_wb_o, dif.dst_reg_identifier_ex_o} !== {5'd3, 5'd10}) begin
         errors++; $display("[TB] FAIL mb_resume got %b want 00011_01010",
                            {dif.dst_reg_identifier_wb_o, dif.dst_reg_identifier_ex_o});
      end
      tick();
   endtask

   task automatic test_flush_and_async_reset();
      drain();
      driveId(1, 1, 0, 9, 0, 0, 0, 0, 0, 1);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL fl_vec got %h want %h", obs, exp); end
      tick();
      driveId(1, 1, 0, 9, 0, 0, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL fl_after_vec got %h want %h", obs, exp); end
      checks++;
      if (dif.valid_ex_o !== 1'b0) begin errors++; $display("[TB] FAIL fl_valid_ex got %b want 0", dif.valid_ex_o); end
      tick();
      driveId(1, 1, 0, 11, 0, 0, 0, 0, 1, 1);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL fl_busy_vec got %h want %h", obs, exp); end
      tick();
      driveId(0, 0, 0, 0, 9, 1, 0, 0, 0, 0);
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL fl_busy_hold_vec got %h want %h", obs, exp); end
      checks++;
      if ({dif.valid_ex_o, dif.dst_reg_identifier_ex_o, dif.depEX_src_a_o} !== {1'b1, 5'd9, 1'b1}) begin
         errors++; $display("[TB] FAIL fl_busy_hold got %b want 1_01001_1",
                            {dif.valid_ex_o, dif.dst_reg_identifier_ex_o, dif.depEX_src_a_o});
      end
      #1;
      rst = 1'b1;
      mEx = '0; mMem = '0; mWb = '0; perfCnt = 0;
      sbq.push_back(modelVec());
      #1;
      exp = sbq.pop_front(); obs = dutVec(); checks++;
      if (obs !== exp) begin errors++; $display("[TB] FAIL async_rst_vec got %h want %h", obs, exp); end
      checks++;
      if (obs !== 28'd0) begin errors++; $display("[TB] FAIL async_rst_zero got %h want 0", obs); end
`ifdef DEP_TRACKER_PERF_CNT_EN
      checks++;
      if (stallCnt !== '0) begin errors++; $display("[TB] FAIL async_rst_cnt got %0d want 0", stallCnt); end
`endif
      tick();
      rst = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         driveId(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 6) == 0));
         exp = sbq.pop_front(); obs = dutVec(); checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL rand_vec[%0d] got %h want %h", i, obs, exp); end
`ifdef DEP_TRACKER_PERF_CNT_EN
         checks++;
         if (stallCnt !== PERF_W'(perfCnt)) begin
            errors++; $display("[TB] FAIL rand_cnt[%0d] got %0d want %0d", i, stallCnt, perfCnt);
         end
`endif
         tick();
      end
   endtask

`ifdef DEP_TRACKER_PERF_CNT_EN
   task automatic test_perf_cnt();
      rst = 1'b1;
      mEx = '0; mMem = '0; mWb = '0; perfCnt = 0;
      driveId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      void'(sbq.pop_front());
      tick();
      rst = 1'b0;
      driveId(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
      void'(sbq.pop_front());
      tick();
      for (int i = 0; i < 3; i++) begin
         driveId(1, 1, 0, 8, 0, 0, 7, 1, (i < 2), 0);
         exp = sbq.pop_front(); obs = dutVec(); checks++;
         if (obs !== exp) begin errors++; $display("[TB] FAIL perf_stall_vec[%0d] got %h want %h", i, obs, exp); end
         tick();
      end
      drain();
      driveId(1, 1, 1, 7, 0, 0, 0, 0, 0, 0);
      void'(sbq.pop_front());
      tick();
      driveId(1, 1, 0, 8, 7, 1, 0, 0, 0, 0);
      void'(sbq.pop_front());
      tick();
      driveId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      void'(sbq.pop_front());
      checks++;
      if (stallCnt !== PERF_W'(2)) begin errors++; $display("[TB] FAIL perf_cnt got %0d want 2", stallCnt); end
   endtask
`endif

   // Scenario sequence, ending with the single summary line
   initial begin
      rst = 1'b1;
      mEx = '0; mMem = '0; mWb = '0; perfCnt = 0;
      dif.id_valid_i = 1'b0; dif.id_wr_i = 1'b0; dif.id_load_i = 1'b0; dif.id_rd_i = '0;
      dif.src_a_identifier_id_i = '0; dif.src_b_identifier_id_i = '0;
      dif.rd_src_a_id_i = 1'b0; dif.rd_src_b_id_i = 1'b0;
      dif.mem_busy_i = 1'b0; dif.flush_i = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_back_to_back();
      test_load_use();
      test_x0();
      test_mem_busy();
      test_flush_and_async_reset();
      test_random();
`ifdef DEP_TRACKER_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dep_tracker_id.md
# dep_tracker_id

Decode-stage dependency tracker that shadows the EX, MEM and WB pipeline slots with destination-register metadata. It compares the decoding instruction's source registers against each in-flight slot and produces per-stage match flags, validity and data-produced flags, and a load-use stall. These outputs drive the ID bypass controller directly. The tracker sits alongside the decoder and advances in lockstep with the pipeline registers.

## Interface
- REG_SIZE, segre_pkg constant (5): register identifier width.
- PERF_W, 32: width of the stall counter (only with DEP_TRACKER_PERF_CNT_EN).

- clk_i  in  1  clock, rising edge.
- rsn_i  in  1  reset, asynchronous, active-high.
- id_valid_i  in  1  ID holds a real instruction.
- id_rd_i  in  REG_SIZE  ID destination register.
- id_wr_i  in  1  ID instruction writes id_rd_i.
- id_load_i  in  1  ID instruction is a load.
- src_a_identifier_id_i / src_b_identifier_id_i  in  REG_SIZE  ID source registers.
- rd_src_a_id_i / rd_src_b_id_i  in  1  source is actually read.
- mem_busy_i  in  1  memory stall; freezes all slots.
- flush_i  in  1  squash the ID instruction (taken branch resolved in EX).
- valid_ex_o / valid_mem_o / valid_wb_o  out  1  slot holds a writing instruction.
- data_produced_ex_o / data_produced_mem_o / data_produced_wb_o  out  1  result is available for bypass from that stage.
- dst_reg_identifier_ex_o / dst_reg_identifier_mem_o / dst_reg_identifier_wb_o  out  REG_SIZE  slot destination.
- depEX_src_a_o, depEX_src_b_o, depMEM_src_a_o, depMEM_src_b_o, depWB_src_a_o, depWB_src_b_o  out  1  raw per-stage match flags.
- stall_id_o  out  1  load-use stall request.
- stall_cnt_o  out  PERF_W  stall cycles counted (only with DEP_TRACKER_PERF_CNT_EN).

## Operation
- Each slot holds a dep_slot_t with fields {valid, wr, load, rd}.
- A slot is writing when valid & wr & (rd != 0). The valid_*_o outputs carry this qualified value.
- data_produced_ex_o = writing(EX) & ~load(EX).
- data_produced_mem_o = writing(MEM).
- data_produced_wb_o = writing(WB).
- depX_src_a_o = writing(X) & rd_src_a_id_i & (src_a == rd(X)) & (src_a != 0). src_b is identical. All combinational.
- Flags are raw. Several may assert at once; the bypass controller resolves priority (EX > MEM > WB).
- stall_id_o = id_valid_i & (depEX_src_a_o | depEX_src_b_o) & load(EX). Combinational.
- Advance = ~mem_busy_i. On advance:
  - WB ← MEM.
  - MEM ← EX.
  - EX ← ID fields with valid = id_valid_i & ~stall_id_o & ~flush_i. Otherwise EX receives a bubble (all fields zero).
- No advance: all slots hold. stall_id_o is still evaluated, but it only changes EX contents on an advancing cycle.

## Timing
- Reset (asynchronous, rsn_i=1): all slots zero. All valid, data_produced, dep and stall outputs are 0. dst outputs are 0. stall_cnt_o is 0.
- Reset deassertion mid-operation: the first advancing edge loads EX from ID normally.
- Insertion latency: an ID instruction appears in EX on the next advancing edge, in MEM 2 edges later, in WB 3 edges later. After WB it retires on the next advance.
- A load-use stall lasts exactly one advancing cycle. The inserted bubble removes the EX match, and the load then sits in MEM with data_produced_mem_o=1.
- Simultaneous flush_i and stall_id_o: EX gets a bubble (same result either way).
- Simultaneous mem_busy_i and flush_i: no state change. flush_i must be held by its source until an advancing cycle.
- rd == 0 never produces a match, never makes a slot writing, and never stalls.

## Configuration
- DEP_TRACKER_PERF_CNT_EN defined:
  - stall_cnt_o exists.
  - It increments by 1 on every clk_i edge where stall_id_o & ~mem_busy_i.
  - It wraps modulo 2^PERF_W and resets to 0.
- Undefined: no counter flops and no stall_cnt_o port. All other behaviour is identical.

## Structure
- segre_pkg gains:
  - dep_slot_t, the packed struct {valid, wr, load, rd[REG_SIZE-1:0]}.
  - DEP_STAGES = 3.
  - Stage index enum {DEP_EX, DEP_MEM, DEP_WB}.
- One sub-module: dep_match. It is a combinational comparator taking (slot, src, rd_src) and returning the match flag. It is instantiated six times.

## Test plan
- Back-to-back ALU, no stalls: ADD x5 in ID, then SUB reading x5 the next cycle → depEX_src_a_o=1, data_produced_ex_o=1, stall_id_o=0. One cycle later depMEM_src_a_o=1; two cycles later depWB_src_a_o=1.
- Load-use: LW x7 followed by ADD reading x7 as src_b → stall_id_o=1 for one cycle and EX receives a bubble. The next cycle shows depMEM_src_b_o=1, data_produced_mem_o=1, stall_id_o=0.
- x0: instruction with id_rd_i=0, id_wr_i=1, followed by a reader of x0 → all dep flags 0 and valid_ex_o=0.
- mem_busy_i held 3 cycles with LW x3 in MEM and a reader of x3 in ID → slots frozen, depMEM_src_a_o=1 throughout. The pipeline resumes on the 4th cycle.
- flush_i with a valid writing instruction x9 in ID → the next cycle has valid_ex_o=0. Asserting rsn_i mid-stream clears all outputs asynchronously, before the next clock edge.
- With DEP_TRACKER_PERF_CNT_EN: two load-use events, one of them overlapping 2 cycles of mem_busy_i → stall_cnt_o=2.
